// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared types and helpers for the parametrised UART frame receiver.
package uart_rx_pkg;

    // Byte-layer receiver states
    typedef enum logic [1:0] {
        BYTE_IDLE,
        BYTE_START,
        BYTE_DATA,
        BYTE_STOP
    } byte_state_e;

    // Flops in the RX pad synchroniser
    localparam int SYNC_DEPTH = 2;

    // Clocks per bit and clocks per half bit
    typedef struct packed {
        logic [31:0] div;
        logic [31:0] half;
    } baud_div_t;

    function automatic baud_div_t calc_baud_div(input logic [31:0] clk_hz,
                                                input logic [31:0] baud_rate);
        baud_div_t r;
        r.div  = clk_hz / baud_rate;
        r.half = r.div >> 1;
        return r;
    endfunction

endpackage

// File: rtl/uart_byte_rx_core.sv
// uart_byte_rx_core: 8N1 byte receiver with a two-flop RX synchroniser.
// Emits a one-cycle byte_stb at the stop-bit centre; byte_ok reflects the stop bit.
module uart_byte_rx_core
    import uart_rx_pkg::*;
#(
    parameter logic [31:0] DIV      = 32'd108,
    parameter logic [31:0] HALF_DIV = 32'd54
) (
    input  logic       clk_100M,
    input  logic       rst,
    input  logic       RX,
    output logic [7:0] byte_data,
    output logic       byte_stb,
    output logic       byte_ok,
    output logic       start_det
);

    logic [SYNC_DEPTH-1:0] sync;
    logic                  rx_s;
    logic                  rx_prev;
    byte_state_e           state, state_nxt;
    logic [31:0]           tick, tick_nxt;
    logic [2:0]            bit_idx, bit_idx_nxt;
    logic [7:0]            shreg, shreg_nxt;

    assign rx_s      = sync[SYNC_DEPTH-1];
    assign byte_data = shreg;

    // Synchronise the pad and keep a delayed copy for falling-edge detection
    always_ff @(posedge clk_100M or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            sync    <= '1;
            rx_prev <= 1'b1;
        end else begin
            sync    <= {sync[SYNC_DEPTH-2:0], RX};
            rx_prev <= rx_s;
        end
    end

    // Byte FSM state and datapath registers
    always_ff @(posedge clk_100M or posedge rst) begin
        if (rst) begin
            state   <= BYTE_IDLE;
            tick    <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            state   <= state_nxt;
            tick    <= tick_nxt;
            bit_idx <= bit_idx_nxt;
            shreg   <= shreg_nxt;
        end
    end

    // Next-state logic: start bit re-checked at mid-bit, data/stop sampled at bit centres
    always_comb begin
        // NOTE: every output gets a default first so no path through the case can infer a latch.
        state_nxt   = state;
        tick_nxt    = tick + 32'd1;
        bit_idx_nxt = bit_idx;
        shreg_nxt   = shreg;
        byte_stb    = 1'b0;
        byte_ok     = 1'b0;
        start_det   = 1'b0;
        case (state)
            BYTE_IDLE: begin
                tick_nxt = '0;
                if (rx_prev && !rx_s) begin
                    state_nxt = BYTE_START;
                    start_det = 1'b1;
                end
            end
            BYTE_START: begin
                if (tick == HALF_DIV - 32'd1) begin
                    tick_nxt    = '0;
                    bit_idx_nxt = '0;
                    state_nxt   = rx_s ? BYTE_IDLE : BYTE_DATA;
                end
            end
            BYTE_DATA: begin
                if (tick == DIV - 32'd1) begin
                    tick_nxt    = '0;
                    shreg_nxt   = {rx_s, shreg[7:1]};
                    bit_idx_nxt = bit_idx + 3'd1;
                    if (bit_idx == 3'd7)
                        state_nxt = BYTE_STOP;
                end
            end
            BYTE_STOP: begin
                if (tick == DIV - 32'd1) begin
                    tick_nxt  = '0;
                    byte_stb  = 1'b1;
                    byte_ok   = rx_s;
                    state_nxt = BYTE_IDLE;
                end
            end
            default: state_nxt = BYTE_IDLE;
        endcase
    end

endmodule

// File: rtl/uart_frame_rx_param.sv
// uart_frame_rx_param: collects PAYLOAD_BYTES payload bytes terminated by TAIL_LEN
// copies of TAIL_BYTE, with framing-error, gap-timeout and short-frame handling.
// Optional build macro FRAME_CHECKSUM_EN: last payload byte must equal the
// mod-256 sum of the preceding payload bytes or the frame is discarded.
module uart_frame_rx_param
    import uart_rx_pkg::*;
#(
    parameter logic [31:0] BAUD_RATE        = 32'd921600,
    parameter logic [31:0] CLK_HZ           = 32'd100_000_000,
    parameter int          PAYLOAD_BYTES    = 3,
    parameter int          TAIL_LEN         = 3,
    parameter logic [7:0]  TAIL_BYTE        = 8'hFF,
    parameter int          GAP_TIMEOUT_BITS = 32
) (
    input  logic                       clk_100M,
    input  logic                       rst,
    input  logic                       RX,
    output logic [8*PAYLOAD_BYTES-1:0] data_frame,
    output logic                       frame_valid,
    output logic                       irq,
    output logic                       frame_err,
    output logic [4:0]                 byte_cnt
);

    localparam int          W          = PAYLOAD_BYTES + TAIL_LEN;
    localparam logic [4:0]  W_CNT      = 5'(W);
    localparam baud_div_t   BAUD_DIV   = calc_baud_div(CLK_HZ, BAUD_RATE);
    localparam logic [31:0] GAP_CYCLES = 32'(GAP_TIMEOUT_BITS) * BAUD_DIV.div;

    logic [7:0]         byte_data;
    logic               byte_stb;
    logic               byte_ok;
    logic               start_det;

    // Only W-1 bytes are held; the incoming byte completes the W-byte window.
    logic [8*(W-1)-1:0] shreg;
    logic [8*W-1:0]     window;
    logic [4:0]         cnt;
    logic [31:0]        gap_tmr;
    logic               tail_hit;
    logic               sum_ok;
    logic               gap_expire;

    uart_byte_rx_core #(
        .DIV      (BAUD_DIV.div),
        .HALF_DIV (BAUD_DIV.half)
    ) u_byte_rx (
        .clk_100M  (clk_100M),
        .rst       (rst),
        .RX        (RX),
        .byte_data (byte_data),
        .byte_stb  (byte_stb),
        .byte_ok   (byte_ok),
        .start_det (start_det)
    );

    assign byte_cnt   = cnt;
    assign gap_expire = (GAP_TIMEOUT_BITS != 0) && (cnt != 5'd0) &&
                        (gap_tmr >= GAP_CYCLES - 32'd1);

`ifdef FRAME_CHECKSUM_EN
    logic [7:0] csum;
`endif

    // Window formation, tail match on the newest W bytes, optional checksum
    always_comb begin
        window   = {shreg, byte_data};
        tail_hit = (cnt >= W_CNT - 5'd1) && (byte_data == TAIL_BYTE);
        for (int i = 0; i < TAIL_LEN - 1; i++)
            if (shreg[8*i +: 8] != TAIL_BYTE)
                tail_hit = 1'b0;
        sum_ok = 1'b1;
`ifdef FRAME_CHECKSUM_EN
        csum = '0;
        for (int i = 0; i < PAYLOAD_BYTES - 1; i++)
            csum = csum + window[8*(W-1-i) +: 8];
        sum_ok = (csum == window[8*(W-PAYLOAD_BYTES) +: 8]);
`endif
    end

    // Frame layer: accept bytes, detect the tail, discard on error or gap timeout
    always_ff @(posedge clk_100M or posedge rst) begin
        if (rst) begin
            shreg       <= '0;
            cnt         <= '0;
            gap_tmr     <= '0;
            data_frame  <= '0;
            frame_valid <= 1'b0;
            irq         <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;

            if (cnt == 5'd0 || start_det || GAP_TIMEOUT_BITS == 0)
                gap_tmr <= '0;
            else
                gap_tmr <= gap_tmr + 32'd1;

            if (gap_expire) begin
                shreg     <= '0;
                cnt       <= '0;
                frame_err <= 1'b1;
            end

            if (byte_stb) begin
                gap_tmr <= '0;
                if (!byte_ok) begin
                    shreg     <= '0;
                    cnt       <= '0;
                    frame_err <= 1'b1;
                end else if (gap_expire) begin
                    // Partial frame timed out in this very cycle: the byte starts a new frame
                    shreg <= (8*(W-1))'(byte_data);
                    cnt   <= 5'd1;
                    irq   <= 1'b0;
                end else if (tail_hit) begin
                    shreg <= '0;
                    cnt   <= '0;
                    if (sum_ok) begin
                        data_frame  <= window[8*W-1 -: 8*PAYLOAD_BYTES];
                        frame_valid <= 1'b1;
                        irq         <= 1'b1;
                    end else begin
                        frame_err <= 1'b1;
                    end
                end else begin
                    shreg <= window[8*(W-1)-1:0];
                    if (cnt != W_CNT)
                        cnt <= cnt + 5'd1;
                    irq <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_frame_rx_param.sv
// tb_uart_frame_rx_param: randomized scoreboard bench for two receiver configurations.
`timescale 1ns/1ps
module tb_uart_frame_rx_param;

    localparam logic [31:0] CLK_HZ = 32'd100_000_000;
    localparam logic [31:0] BAUD   = 32'd10_000_000;
    localparam int          BITC   = 10;          // clocks per bit
    localparam int          PB0 = 3, TL0 = 3, GAP0 = 32;
    localparam logic [7:0]  TB0 = 8'hFF;
    localparam int          PB1 = 4, TL1 = 2, GAP1 = 0;
    localparam logic [7:0]  TB1 = 8'h0D;
`ifdef FRAME_CHECKSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif
    localparam logic [1:0] EV_VALID = 2'b10;
    localparam logic [1:0] EV_ERR   = 2'b01;

    logic clk_100M = 1'b0;
    logic rst = 1'b1;
    logic rx0 = 1'b1, rx1 = 1'b1;
    logic [8*PB0-1:0] df0;
    logic [8*PB1-1:0] df1;
    logic fv0, irq0, fe0, fv1, irq1, fe1;
    logic [4:0] bc0, bc1;

    always #5 clk_100M = ~clk_100M;

    uart_frame_rx_param #(.BAUD_RATE(BAUD), .CLK_HZ(CLK_HZ), .PAYLOAD_BYTES(PB0),
        .TAIL_LEN(TL0), .TAIL_BYTE(TB0), .GAP_TIMEOUT_BITS(GAP0)) dut0 (
        .clk_100M(clk_100M), .rst(rst), .RX(rx0), .data_frame(df0),
        .frame_valid(fv0), .irq(irq0), .frame_err(fe0), .byte_cnt(bc0));

    uart_frame_rx_param #(.BAUD_RATE(BAUD), .CLK_HZ(CLK_HZ), .PAYLOAD_BYTES(PB1),
        .TAIL_LEN(TL1), .TAIL_BYTE(TB1), .GAP_TIMEOUT_BITS(GAP1)) dut1 (
        .clk_100M(clk_100M), .rst(rst), .RX(rx1), .data_frame(df1),
        .frame_valid(fv1), .irq(irq1), .frame_err(fe1), .byte_cnt(bc1));

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct { logic [1:0] kind; logic [31:0] data; } ev_t;
    ev_t        q0[$], q1[$];
    logic [7:0] hist0[$], hist1[$];
    bit         irq_m [2];
    logic [31:0] held_m [2];
    logic [7:0] seq[$];

    function automatic int pbytes(input int d); return (d == 0) ? PB0 : PB1; endfunction
    function automatic int tlen(input int d);   return (d == 0) ? TL0 : TL1; endfunction
    function automatic int gapb(input int d);   return (d == 0) ? GAP0 : GAP1; endfunction
    function automatic logic [7:0] tbyte(input int d); return (d == 0) ? TB0 : TB1; endfunction

    task automatic push_ev(input int d, input logic [1:0] kind, input logic [31:0] data);
        ev_t e;
        e.kind = kind;
        e.data = data;
        if (d == 0) q0.push_back(e); else q1.push_back(e);
    endtask

    function automatic int hist_size(input int d);
        return (d == 0) ? hist0.size() : hist1.size();
    endfunction

    // Apply one received byte to the frame rules: newest W bytes decide a match.
    task automatic model_byte(input int d, input logic [7:0] b, input bit ok);
        logic [7:0]  h[$];
        int          w, pb;
        bit          hit;
        logic [31:0] pay;
        logic [7:0]  sum;
        pb = pbytes(d);
        w  = pb + tlen(d);
        if (d == 0) h = hist0; else h = hist1;
        if (!ok) begin
            h.delete();
            push_ev(d, EV_ERR, held_m[d]);
        end else begin
            h.push_back(b);
            hit = (h.size() >= w);
            for (int i = 0; i < tlen(d); i++)
                if (hit && h[h.size()-1-i] != tbyte(d)) hit = 1'b0;
            if (hit) begin
                pay = 0;
                sum = 0;
                for (int i = 0; i < pb; i++) pay = (pay << 8) | 32'(h[h.size()-w+i]);
                for (int i = 0; i < pb - 1; i++) sum = sum + h[h.size()-w+i];
                if (CSUM && sum != h[h.size()-w+pb-1]) begin
                    push_ev(d, EV_ERR, held_m[d]);
                end else begin
                    held_m[d] = pay;
                    irq_m[d]  = 1'b1;
                    push_ev(d, EV_VALID, pay);
                end
                h.delete();
            end else begin
                irq_m[d] = 1'b0;
            end
        end
        if (d == 0) hist0 = h; else hist1 = h;
    endtask

    // ---------------- stimulus ----------------
    task automatic drive(input int d, input logic v);
        if (d == 0) rx0 = v; else rx1 = v;
    endtask

    task automatic idle_bits(input int d, input int n);
        if (gapb(d) > 0 && n >= gapb(d) && hist_size(d) > 0) begin
            push_ev(d, EV_ERR, held_m[d]);
            if (d == 0) hist0.delete(); else hist1.delete();
        end
        repeat (n * BITC) @(negedge clk_100M);
    endtask

    task automatic send_byte(input int d, input logic [7:0] b, input bit stop_ok);
        int w;
        int exp_cnt;
        w = pbytes(d) + tlen(d);
        model_byte(d, b, stop_ok);
        drive(d, 1'b0);
        repeat (BITC) @(negedge clk_100M);
        for (int i = 0; i < 8; i++) begin
            drive(d, b[i]);
            repeat (BITC) @(negedge clk_100M);
        end
        drive(d, stop_ok);
        repeat (BITC) @(negedge clk_100M);
        drive(d, 1'b1);
        repeat (3) @(negedge clk_100M);
        exp_cnt = (hist_size(d) > w) ? w : hist_size(d);
        if (d == 0) begin
            check("dut0 byte_cnt", bc0, exp_cnt);
            check("dut0 irq", irq0, irq_m[0]);
        end else begin
            check("dut1 byte_cnt", bc1, exp_cnt);
            check("dut1 irq", irq1, irq_m[1]);
        end
    endtask

    // Send the bytes in seq with one idle bit between; bad_idx gets a zero stop bit
    task automatic send_list(input int d, input int bad_idx);
        for (int i = 0; i < seq.size(); i++) begin
            send_byte(d, seq[i], i != bad_idx);
            idle_bits(d, 1);
        end
    endtask

    task automatic rand_frames(input int d, input int n);
        logic [7:0] pay[$];
        logic [7:0] sum;
        int         pb;
        for (int f = 0; f < n; f++) begin
            pb = pbytes(d);
            pay.delete();
            sum = 0;
            for (int i = 0; i < pb; i++) begin
                pay.push_back(($urandom_range(0, 3) == 0) ? tbyte(d) : 8'($urandom));
                if (i < pb - 1) sum = sum + pay[i];
            end
            if ($urandom_range(0, 1) == 1) pay[pb-1] = sum;
            for (int i = 0; i < pb; i++) begin
                send_byte(d, pay[i], $urandom_range(0, 29) != 0);
                idle_bits(d, $urandom_range(0, 2));
            end
            if ($urandom_range(0, 9) < 8) begin
                for (int i = 0; i < tlen(d); i++) begin
                    send_byte(d, tbyte(d), $urandom_range(0, 29) != 0);
                    idle_bits(d, $urandom_range(0, 2));
                end
            end else begin
                send_byte(d, 8'($urandom), 1'b1);
            end
            if ($urandom_range(0, 9) == 0) idle_bits(d, 40);
        end
    endtask

    // ---------------- scoreboard monitors ----------------
    ev_t m0, m1;

    always @(negedge clk_100M) begin
        if (!rst && (fv0 || fe0)) begin
            if (q0.size() == 0) begin
                check("dut0 unexpected event", {fv0, fe0}, 2'b00);
            end else begin
                m0 = q0.pop_front();
                check("dut0 event kind", {fv0, fe0}, m0.kind);
                check("dut0 data_frame", df0, m0.data);
            end
        end
    end

    always @(negedge clk_100M) begin
        if (!rst && (fv1 || fe1)) begin
            if (q1.size() == 0) begin
                check("dut1 unexpected event", {fv1, fe1}, 2'b00);
            end else begin
                m1 = q1.pop_front();
                check("dut1 event kind", {fv1, fe1}, m1.kind);
                check("dut1 data_frame", df1, m1.data);
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, " outputs dut0"}, {df0, fv0, irq0, fe0, bc0}, 0);
        check({tag, " outputs dut1"}, {df1, fv1, irq1, fe1, bc1}, 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        irq_m[0] = 0; irq_m[1] = 0; held_m[0] = 0; held_m[1] = 0;
        repeat (4) @(negedge clk_100M);
        check_all_zero("reset");
        rst = 1'b0;
        repeat (2 * BITC) @(negedge clk_100M);
        check_all_zero("post-reset");

        seq = '{8'h12, 8'h34, 8'h56, 8'hFF, 8'hFF, 8'hFF};               send_list(0, -1);
        seq = '{8'hFF, 8'h12, 8'hFF, 8'hFF, 8'hFF, 8'hFF};               send_list(0, -1);
        seq = '{8'hAA, 8'hAA, 8'h01, 8'h02, 8'h03, 8'hFF, 8'hFF, 8'hFF}; send_list(0, -1);
        seq = '{8'h12, 8'h34, 8'h56, 8'hFF, 8'hFF, 8'hFF};               send_list(0, 1);
        idle_bits(0, 40);
        seq = '{8'h12, 8'h34};                                           send_list(0, -1);
        idle_bits(0, 40);
        seq = '{8'h56, 8'hFF, 8'hFF, 8'hFF};                             send_list(0, -1);
        idle_bits(0, 40);
        seq = '{8'h01, 8'h02, 8'h03, 8'hFF, 8'hFF, 8'hFF};               send_list(0, -1);
        seq = '{8'h01, 8'h02, 8'h04, 8'hFF, 8'hFF, 8'hFF};               send_list(0, -1);

        seq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h0D, 8'h0D};               send_list(1, -1);
        seq = '{8'h05, 8'h0D};                                           send_list(1, -1);
        idle_bits(1, 40);
        seq = '{8'h0D, 8'h01, 8'h02, 8'h03, 8'h06, 8'h0D, 8'h0D};        send_list(1, -1);

        rand_frames(0, 20);
        idle_bits(0, 40);
        rand_frames(1, 20);
        idle_bits(1, 4);

        // Reset in the middle of a byte, with a partial frame held in dut0
        seq = '{8'h21, 8'h22};                                           send_list(0, -1);
        check("events drained before reset", q0.size() + q1.size(), 0);
        rx0 = 1'b0;
        repeat (35) @(negedge clk_100M);
        rst = 1'b1;
        @(negedge clk_100M);
        rx0 = 1'b1;
        check_all_zero("mid-byte reset");
        hist0.delete(); hist1.delete();
        irq_m[0] = 0; irq_m[1] = 0; held_m[0] = 0; held_m[1] = 0;
        repeat (5) @(negedge clk_100M);
        rst = 1'b0;
        repeat (2 * BITC) @(negedge clk_100M);
        seq = '{8'h0A, 8'h0B, 8'h15, 8'hFF, 8'hFF, 8'hFF};               send_list(0, -1);

        idle_bits(0, 40);
        idle_bits(1, 40);
        check("dut0 scoreboard drained", q0.size(), 0);
        check("dut1 scoreboard drained", q1.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
